// File: rtl/writeback_unit.sv
// Register-file write port: merges the MEM/WB pipeline result with a small FIFO of
// long-latency results. Sub-word load extraction is built only when WB_LOAD_EXT_EN is defined.
module writeback_unit #(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LL_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic                  wb_mem_to_reg,
    input  logic [DATA_W-1:0]     wb_alu_result,
    input  logic [DATA_W-1:0]     wb_mem_data,
    input  logic [2:0]            wb_load_type,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [REG_ADDR_W-1:0] ll_write_reg,
    input  logic [DATA_W-1:0]     ll_data,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic                  ll_pending,
    output logic                  stall_req
);

    localparam int PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
    localparam int CNT_W = $clog2(LL_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LL_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    logic [REG_ADDR_W-1:0] fifo_reg_r  [LL_DEPTH];
    logic [DATA_W-1:0]     fifo_data_r [LL_DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic [STV_W-1:0]      starve_r;

    logic                  fifo_nonempty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  pipe_cand_s;
    logic                  pipe_win_s;
    logic [REG_ADDR_W-1:0] head_reg_s;
    logic [DATA_W-1:0]     head_data_s;
    logic [DATA_W-1:0]     pipe_data_s;
    logic                  nxt_we_s;
    logic [REG_ADDR_W-1:0] nxt_reg_s;
    logic [DATA_W-1:0]     nxt_data_s;
    logic [STV_W-1:0]      starve_nxt_s;
    logic                  stall_nxt_s;

`ifdef WB_LOAD_EXT_EN
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [2:0]        ltype,
        input logic [1:0]        off,
        input logic [DATA_W-1:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [DATA_W-1:0] res_v;
        byte_v = word[{off, 3'b000} +: 8];
        half_v = word[{off[1], 4'b0000} +: 16];
        case (ltype)
            3'b001:  res_v = {{(DATA_W-8){byte_v[7]}}, byte_v};
            3'b010:  res_v = {{(DATA_W-8){1'b0}}, byte_v};
            3'b011:  res_v = {{(DATA_W-16){half_v[15]}}, half_v};
            3'b100:  res_v = {{(DATA_W-16){1'b0}}, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    // Pipeline result with little-endian sub-word load extraction
    always_comb begin
        if (wb_mem_to_reg) begin
            pipe_data_s = load_extract(wb_load_type, wb_alu_result[1:0], wb_mem_data);
        end else begin
            pipe_data_s = wb_alu_result;
        end
    end
`else
    logic unused_load_type_s;
    assign unused_load_type_s = ^wb_load_type;

    // Pipeline result; loads pass the raw memory word through
    always_comb begin
        if (wb_mem_to_reg) begin
            pipe_data_s = wb_mem_data;
        end else begin
            pipe_data_s = wb_alu_result;
        end
    end
`endif

    assign fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
    assign ll_ready        = (count_r < DEPTH_C);
    assign ll_pending      = fifo_nonempty_s;
    assign push_s          = ll_valid & ll_ready;
    assign head_reg_s      = fifo_reg_r[head_r];
    assign head_data_s     = fifo_data_r[head_r];
    assign pipe_cand_s     = wb_valid & wb_reg_write &
                             (wb_write_reg != {REG_ADDR_W{1'b0}}) & ~stall_req;

    // Arbitration: a pending stall forces the FIFO head, else the pipeline has priority
    always_comb begin
        pop_s      = 1'b0;
        pipe_win_s = 1'b0;
        nxt_we_s   = 1'b0;
        nxt_reg_s  = {REG_ADDR_W{1'b0}};
        nxt_data_s = {DATA_W{1'b0}};
        if (stall_req) begin
            pop_s = fifo_nonempty_s;
        end else if (pipe_cand_s) begin
            pipe_win_s = 1'b1;
        end else if (fifo_nonempty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (pipe_win_s) begin
            nxt_we_s   = 1'b1;
            nxt_reg_s  = wb_write_reg;
            nxt_data_s = pipe_data_s;
        end else if (pop_s && (head_reg_s != {REG_ADDR_W{1'b0}})) begin
            nxt_we_s   = 1'b1;
            nxt_reg_s  = head_reg_s;
            nxt_data_s = head_data_s;
        end else begin
            nxt_we_s   = 1'b0;
        end
    end

    // Starvation tracking; stall_req rises only on the edge the counter hits the limit
    always_comb begin
        if (pop_s) begin
            starve_nxt_s = {STV_W{1'b0}};
        end else if (fifo_nonempty_s && pipe_win_s && (starve_r != LIMIT_C)) begin
            starve_nxt_s = starve_r + STV_W'(1);
        end else begin
            starve_nxt_s = starve_r;
        end
        stall_nxt_s = (starve_nxt_s == LIMIT_C) & ~pop_s;
    end

    // Long-latency result FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < LL_DEPTH; i++) begin
                fifo_reg_r[i]  <= {REG_ADDR_W{1'b0}};
                fifo_data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_reg_r[tail_r]  <= ll_write_reg;
                fifo_data_r[tail_r] <= ll_data;
                tail_r              <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Starve counter and stall request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r  <= {STV_W{1'b0}};
            stall_req <= 1'b0;
        end else begin
            starve_r  <= starve_nxt_s;
            stall_req <= stall_nxt_s;
        end
    end

    // Registered register-file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= {REG_ADDR_W{1'b0}};
            write_data <= {DATA_W{1'b0}};
        end else begin
            reg_write  <= nxt_we_s;
            write_reg  <= nxt_reg_s;
            write_data <= nxt_data_s;
        end
    end

endmodule
